// File: rtl/huff_symbol_counter_pkg.sv
// Shared constants, state encoding and symbol-to-bin mapping for the Huffman
// symbol counter.
package huff_pkg;

  localparam int NUM_SYM = 6;
  localparam int SYM_W   = 8;
  localparam int TOTAL   = 100;
  localparam int CNT_W   = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    COUNT = S_COUNT,
    DONE  = S_DONE,
    HOLD  = S_HOLD
  } state_t;

  typedef struct packed {
    logic        ok;
    logic [31:0] idx;
  } bin_sel_t;

  // Symbols are 1-based on the wire; bins are 0-based. Width-agnostic so a
  // top with overridden SYM_W/NUM_SYM can reuse it.
  function automatic bin_sel_t sym_to_bin(input logic [31:0] sym,
                                          input int unsigned num_sym);
    bin_sel_t r;
    r.ok  = (sym >= 32'd1) && (sym <= num_sym);
    r.idx = r.ok ? (sym - 32'd1) : 32'd0;
    return r;
  endfunction

endpackage

// File: rtl/huff_symbol_counter_if.sv
// Symbol input, controller acknowledge and count result bundle.
interface huff_symbol_counter_if #(
  parameter int NUM_SYM = huff_pkg::NUM_SYM,
  parameter int SYM_W   = huff_pkg::SYM_W,
  parameter int CNT_W   = huff_pkg::CNT_W
);
  logic                     gray_valid;
  logic [SYM_W-1:0]         gray_data;
  logic                     CNT_valid;
  logic                     CNT_end;
  logic [NUM_SYM*CNT_W-1:0] cnt_bus;
  logic                     busy;
  logic                     sym_err;
  logic                     drop_err;

  modport master (
    output gray_valid, gray_data, CNT_valid,
    input  CNT_end, cnt_bus, busy, sym_err, drop_err
  );

  modport slave (
    input  gray_valid, gray_data, CNT_valid,
    output CNT_end, cnt_bus, busy, sym_err, drop_err
  );
endinterface

// File: rtl/huff_symbol_counter_bin_cnt.sv
// One saturating occurrence bin; clear and enable together load a count of 1.
module huff_bin_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = en ? CNT_W'(1) : '0;
    end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/huff_symbol_counter.sv
// Per-symbol frame histogram for the Huffman controller: counts TOTAL symbols,
// flags completion, then freezes the bins until the next frame starts.
module huff_symbol_counter
  import huff_pkg::*;
#(
  parameter int NUM_SYM = huff_pkg::NUM_SYM,
  parameter int SYM_W   = huff_pkg::SYM_W,
  parameter int TOTAL   = huff_pkg::TOTAL,
  parameter int CNT_W   = huff_pkg::CNT_W
) (
  input logic clk,
  input logic reset,
  huff_symbol_counter_if.slave ifc
);

  localparam int TOT_W = $clog2(TOTAL + 1);

  state_t           state_q, state_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic             cnt_end_q, cnt_end_d;
  logic             busy_q, busy_d;
  logic             sym_err_q, sym_err_d;
  logic             drop_err_q, drop_err_d;
  logic             bin_clr;
  logic             sym_acc;
  bin_sel_t         sel;
  logic [NUM_SYM-1:0] bin_en;
  logic [CNT_W-1:0]   bin_cnt [NUM_SYM];

  assign sel = sym_to_bin(32'(ifc.gray_data), NUM_SYM);

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    cnt_end_d  = cnt_end_q;
    busy_d     = busy_q;
    sym_err_d  = sym_err_q;
    drop_err_d = drop_err_q;
    bin_clr    = 1'b0;
    sym_acc    = 1'b0;
    case (state_q)
      IDLE, HOLD: begin
        // First symbol of a frame wipes the previous frame's results.
        if (ifc.gray_valid) begin
          bin_clr    = 1'b1;
          sym_acc    = 1'b1;
          total_d    = TOT_W'(1);
          sym_err_d  = ~sel.ok;
          drop_err_d = 1'b0;
          if (TOTAL == 1) begin
            state_d   = DONE;
            cnt_end_d = 1'b1;
            busy_d    = 1'b0;
          end else begin
            state_d   = COUNT;
            cnt_end_d = 1'b0;
            busy_d    = 1'b1;
          end
        end
      end
      COUNT: begin
        if (ifc.gray_valid) begin
          sym_acc   = 1'b1;
          total_d   = total_q + TOT_W'(1);
          sym_err_d = sym_err_q | ~sel.ok;
          if (total_q == TOT_W'(TOTAL - 1)) begin
            state_d   = DONE;
            cnt_end_d = 1'b1;
            busy_d    = 1'b0;
          end
        end
      end
      DONE: begin
        if (ifc.gray_valid) drop_err_d = 1'b1;
        if (ifc.CNT_valid) begin
          state_d   = HOLD;
          cnt_end_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      total_q    <= '0;
      cnt_end_q  <= 1'b0;
      busy_q     <= 1'b0;
      sym_err_q  <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      cnt_end_q  <= cnt_end_d;
      busy_q     <= busy_d;
      sym_err_q  <= sym_err_d;
      drop_err_q <= drop_err_d;
    end
  end

  for (genvar k = 0; k < NUM_SYM; k++) begin : g_bin
    assign bin_en[k] = sym_acc && sel.ok && (sel.idx == 32'(k));

    huff_bin_cnt #(.CNT_W(CNT_W)) u_bin (
      .clk   (clk),
      .rst_n (reset),
      .clr   (bin_clr),
      .en    (bin_en[k]),
      .cnt   (bin_cnt[k])
    );

    assign ifc.cnt_bus[k*CNT_W +: CNT_W] = bin_cnt[k];
  end

  assign ifc.CNT_end  = cnt_end_q;
  assign ifc.busy     = busy_q;
  assign ifc.sym_err  = sym_err_q;
  assign ifc.drop_err = drop_err_q;

endmodule

// File: tb/tb_huff_symbol_counter.sv
// Directed bench for huff_symbol_counter: default frame plus a TOTAL=300 copy
// exercising bin saturation.
module tb_huff_symbol_counter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  huff_symbol_counter_if #(.NUM_SYM(6), .SYM_W(8), .CNT_W(8)) if1 ();
  huff_symbol_counter_if #(.NUM_SYM(6), .SYM_W(8), .CNT_W(8)) if2 ();

  huff_symbol_counter #(.NUM_SYM(6), .SYM_W(8), .TOTAL(100), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .ifc   (if1.slave)
  );

  huff_symbol_counter #(.NUM_SYM(6), .SYM_W(8), .TOTAL(300), .CNT_W(8)) dut300 (
    .clk   (clk),
    .reset (reset),
    .ifc   (if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send1(input logic [7:0] sym);
    @(negedge clk);
    if1.gray_valid = 1'b1;
    if1.gray_data  = sym;
    if1.CNT_valid  = 1'b0;
  endtask

  task automatic send2(input logic [7:0] sym);
    @(negedge clk);
    if2.gray_valid = 1'b1;
    if2.gray_data  = sym;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if1.gray_valid = 1'b0;
      if1.CNT_valid  = 1'b0;
      if2.gray_valid = 1'b0;
      if2.CNT_valid  = 1'b0;
    end
  endtask

  task automatic ack1();
    @(negedge clk);
    if1.gray_valid = 1'b0;
    if1.CNT_valid  = 1'b1;
    idle(1);
  endtask

  localparam logic [47:0] CYC_BINS = {8'd16, 8'd16, 8'd17, 8'd17, 8'd17, 8'd17};
  localparam logic [47:0] B2_99    = 48'd99 << 16;
  localparam logic [47:0] B5_1     = 48'd1 << 40;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    if1.gray_valid = 1'b0; if1.gray_data = '0; if1.CNT_valid = 1'b0;
    if2.gray_valid = 1'b0; if2.gray_data = '0; if2.CNT_valid = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_cnt_end",  64'(if1.CNT_end),  64'd0);
    chk("rst_busy",     64'(if1.busy),     64'd0);
    chk("rst_sym_err",  64'(if1.sym_err),  64'd0);
    chk("rst_drop_err", 64'(if1.drop_err), 64'd0);
    chk("rst_bus",      64'(if1.cnt_bus),  64'd0);
    reset = 1'b1;

    // Continuous 1..6 cycling frame
    for (int i = 0; i < 99; i++) send1(8'((i % 6) + 1));
    idle(1);
    chk("cyc99_cnt_end", 64'(if1.CNT_end), 64'd0);
    chk("cyc99_busy",    64'(if1.busy),    64'd1);
    send1(8'((99 % 6) + 1));
    idle(1);
    chk("cyc_cnt_end", 64'(if1.CNT_end), 64'd1);
    chk("cyc_busy",    64'(if1.busy),    64'd0);
    chk("cyc_bus",     64'(if1.cnt_bus), 64'(CYC_BINS));
    chk("cyc_sym_err", 64'(if1.sym_err), 64'd0);
    ack1();
    chk("ack_cnt_end", 64'(if1.CNT_end), 64'd0);
    chk("hold_bus",    64'(if1.cnt_bus), 64'(CYC_BINS));

    // Same stream with 0-3 idle cycles between symbols
    for (int i = 0; i < 100; i++) begin
      send1(8'((i % 6) + 1));
      idle(i % 4);
    end
    idle(1);
    chk("gap_bus",     64'(if1.cnt_bus), 64'(CYC_BINS));
    chk("gap_cnt_end", 64'(if1.CNT_end), 64'd1);
    idle(10);
    chk("gap_end_held", 64'(if1.CNT_end), 64'd1);
    chk("gap_bus_held", 64'(if1.cnt_bus), 64'(CYC_BINS));
    @(negedge clk);
    if1.CNT_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("gap_ack_fall", 64'(if1.CNT_end), 64'd0);
    idle(1);

    // 99 x symbol 3 plus one out-of-range symbol 0
    for (int i = 0; i < 99; i++) send1(8'd3);
    send1(8'd0);
    idle(1);
    chk("oor_bus",     64'(if1.cnt_bus), 64'(B2_99));
    chk("oor_sym_err", 64'(if1.sym_err), 64'd1);
    chk("oor_cnt_end", 64'(if1.CNT_end), 64'd1);

    // Extra symbols while DONE are dropped
    for (int i = 0; i < 5; i++) send1(8'd1);
    idle(1);
    chk("drop_bus",      64'(if1.cnt_bus),  64'(B2_99));
    chk("drop_err",      64'(if1.drop_err), 64'd1);
    chk("drop_cnt_end",  64'(if1.CNT_end),  64'd1);
    // Symbol coincident with the acknowledge is also dropped
    @(negedge clk);
    if1.gray_valid = 1'b1; if1.gray_data = 8'd2; if1.CNT_valid = 1'b1;
    idle(1);
    chk("coinc_cnt_end", 64'(if1.CNT_end), 64'd0);
    chk("coinc_bus",     64'(if1.cnt_bus), 64'(B2_99));
    chk("coinc_busy",    64'(if1.busy),    64'd0);
    send1(8'd6);
    idle(1);
    chk("new_bus",      64'(if1.cnt_bus),  64'(B5_1));
    chk("new_sym_err",  64'(if1.sym_err),  64'd0);
    chk("new_drop_err", 64'(if1.drop_err), 64'd0);
    chk("new_busy",     64'(if1.busy),     64'd1);

    // Reset in the middle of a frame (1 + 49 = 50 symbols)
    for (int i = 0; i < 49; i++) send1(8'((i % 6) + 1));
    idle(1);
    reset = 1'b0;
    #1;
    chk("mid_rst_bus",  64'(if1.cnt_bus), 64'd0);
    chk("mid_rst_busy", 64'(if1.busy),    64'd0);
    chk("mid_rst_serr", 64'(if1.sym_err), 64'd0);
    chk("mid_rst_derr", 64'(if1.drop_err), 64'd0);
    chk("mid_rst_end",  64'(if1.CNT_end), 64'd0);
    idle(2);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) send1(8'((i % 6) + 1));
    idle(1);
    chk("post_rst_bus", 64'(if1.cnt_bus), 64'(CYC_BINS));
    chk("post_rst_end", 64'(if1.CNT_end), 64'd1);

    // TOTAL=300 instance: bin 0 saturates at 255
    for (int i = 0; i < 299; i++) send2(8'd1);
    idle(1);
    chk("t300_299_bus", 64'(if2.cnt_bus), 64'hFF);
    chk("t300_299_end", 64'(if2.CNT_end), 64'd0);
    send2(8'd1);
    idle(1);
    chk("t300_end",     64'(if2.CNT_end), 64'd1);
    chk("t300_bus",     64'(if2.cnt_bus), 64'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
